// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, default widths
// and the access-type encoding used on the rwN inputs.
package data_mem_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DEPTH_DEF  = 16;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The priority bit names the preferred requester
// and flips to the loser whenever a grant is taken.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic       o_valid,
   output logic       o_grant
);

   logic r_prio;

   always_comb begin
      o_valid = i_req[0] | i_req[1];
      if (i_req[0] && i_req[1]) begin
         o_grant = r_prio;
      end else begin
         o_grant = i_req[1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_prio <= 1'b0;
      end else if (i_advance && o_valid) begin
         r_prio <= ~o_grant;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto a single-port data memory with an
// IDLE -> ACCESS -> RESP sequence; one access completes every three cycles.
module data_mem_arbiter
   import data_mem_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              rw0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_memwrite,
   output logic              mem_memread,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            r_state;
   state_t            w_next_state;
   logic              w_valid;
   logic              w_grant;
   logic              w_advance;
   logic              w_sel_rw;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   logic              r_grant;
   logic              r_oor;
   logic              r_memwrite;
   logic              r_memread;
   logic              r_err;
   logic [ADDR_W-1:0] r_address;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   assign w_advance = (r_state == ST_IDLE);

   rr_arb2 u_arb (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_req     ({req1, req0}),
      .i_advance (w_advance),
      .o_valid   (w_valid),
      .o_grant   (w_grant)
   );

   always_comb begin
      w_sel_rw    = w_grant ? rw1    : rw0;
      w_sel_addr  = w_grant ? addr1  : addr0;
      w_sel_wdata = w_grant ? wdata1 : wdata0;
      w_in_range  = (w_sel_addr < ADDR_W'(DEPTH));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = ST_IDLE;
      case (r_state)
         ST_IDLE:   w_next_state = w_valid ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: w_next_state = ST_RESP;
         ST_RESP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // Strobes are only armed for in-range addresses, so an out-of-range access
   // never touches the memory; the response registers are cleared leaving RESP.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_grant    <= 1'b0;
         r_oor      <= 1'b0;
         r_memwrite <= 1'b0;
         r_memread  <= 1'b0;
         r_err      <= 1'b0;
         r_address  <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_grant    <= w_grant;
                  r_address  <= w_sel_addr;
                  r_wdata    <= w_sel_wdata;
                  r_oor      <= ~w_in_range;
                  r_memwrite <= (w_sel_rw == RW_WRITE) && w_in_range;
                  r_memread  <= (w_sel_rw == RW_READ) && w_in_range;
               end
            end
            ST_ACCESS: begin
               r_memwrite <= 1'b0;
               r_memread  <= 1'b0;
               r_rdata    <= r_memread ? mem_rdata : '0;
               r_err      <= r_oor;
            end
            ST_RESP: begin
               r_grant   <= 1'b0;
               r_oor     <= 1'b0;
               r_err     <= 1'b0;
               r_address <= '0;
               r_wdata   <= '0;
               r_rdata   <= '0;
            end
            default: begin
               r_memwrite <= 1'b0;
               r_memread  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      ack0         = (r_state == ST_RESP) && !r_grant;
      ack1         = (r_state == ST_RESP) && r_grant;
      rdata        = (r_state == ST_RESP) ? r_rdata : '0;
      err          = (r_state == ST_RESP) && r_err;
      busy         = (r_state != ST_IDLE);
      mem_address  = r_address;
      mem_wdata    = r_wdata;
      mem_memwrite = r_memwrite;
      mem_memread  = r_memread;
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 16x16 behavioural data memory.
module tb_data_mem_arbiter;
   import data_mem_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 16;
   localparam int unsigned DP = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          req0, rw0, req1, rw1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, err, busy, mem_memwrite, mem_memread;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_address;

   logic [DW-1:0] mem [DP];
   logic          mem_load;
   bit            mon_en = 1'b0;
   int            errors = 0;
   int            checks = 0;
   int unsigned   n_ack0 = 0;
   int unsigned   n_ack1 = 0;

   always #5 clock = ~clock;

   data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .err(err), .busy(busy),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
      .mem_rdata(mem_rdata)
   );

   // Existing memory: combinational read, write on the clock edge.
   assign mem_rdata = mem[mem_address[3:0]];
   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
      end else if (mem_memwrite) begin
         mem[mem_address[3:0]] <= mem_wdata;
      end
   end

   always @(negedge clock) begin
      if (mon_en && !reset) begin
         checks++;
         if (mem_memwrite && mem_memread) begin
            errors++; $display("FAIL strobe_excl: write=%b read=%b required not both 1", mem_memwrite, mem_memread);
         end
         checks++;
         if ((ack0 || ack1) && (!busy || (ack0 && ack1) || mem_memwrite || mem_memread)) begin
            errors++; $display("FAIL ack_outside_resp: ack0=%b ack1=%b busy=%b wr=%b rd=%b", ack0, ack1, busy, mem_memwrite, mem_memread);
         end
         if (ack0) n_ack0++;
         if (ack1) n_ack1++;
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic reset_dut();
      @(negedge clock);
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clock);
      @(negedge clock);
      mem_load = 1'b0;
      checks++;
      if ({ack0, ack1, err, busy, mem_memwrite, mem_memread} !== 6'b0) begin
         errors++; $display("FAIL reset_flags: got %b required 000000", {ack0, ack1, err, busy, mem_memwrite, mem_memread});
      end
      checks++;
      if (rdata !== 16'h0 || mem_address !== 16'h0 || mem_wdata !== 16'h0) begin
         errors++; $display("FAIL reset_buses: rdata=%h addr=%h wdata=%h required 0", rdata, mem_address, mem_wdata);
      end
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || mem_memwrite !== 1'b0 || mem_memread !== 1'b0 || mem_address !== 16'h0) begin
         errors++; $display("FAIL idle_no_req: busy=%b wr=%b rd=%b addr=%h required all 0", busy, mem_memwrite, mem_memread, mem_address);
      end
   endtask

   task automatic test_write_read();
      @(negedge clock);
      reset = 1'b1; req0 = 1'b1; rw0 = RW_WRITE; addr0 = 16'd3; wdata0 = 16'hBEEF;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || mem_memwrite !== 1'b0) begin
         errors++; $display("FAIL hold_in_reset: busy=%b wr=%b required 0", busy, mem_memwrite);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (mem_memwrite !== 1'b1 || mem_memread !== 1'b0) begin
         errors++; $display("FAIL wr_access_strobe: wr=%b rd=%b required 1/0", mem_memwrite, mem_memread);
      end
      checks++;
      if (mem_address !== 16'd3 || mem_wdata !== 16'hBEEF || ack0 !== 1'b0) begin
         errors++; $display("FAIL wr_access_bus: addr=%h wdata=%h ack0=%b required 0003/beef/0", mem_address, mem_wdata, ack0);
      end
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 16'h0 || err !== 1'b0) begin
         errors++; $display("FAIL wr_resp: ack0=%b ack1=%b rdata=%h err=%b required 1/0/0000/0", ack0, ack1, rdata, err);
      end
      rw0 = RW_READ; wdata0 = 16'h0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || mem_address !== 16'h0 || ack0 !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: busy=%b addr=%h ack0=%b required 0", busy, mem_address, ack0);
      end
      @(negedge clock);
      checks++;
      if (mem_memread !== 1'b1 || mem_memwrite !== 1'b0) begin
         errors++; $display("FAIL rd_access_strobe: rd=%b wr=%b required 1/0", mem_memread, mem_memwrite);
      end
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1 || rdata !== 16'hBEEF || err !== 1'b0) begin
         errors++; $display("FAIL rd_resp: ack0=%b rdata=%h err=%b required 1/beef/0", ack0, rdata, err);
      end
      req0 = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || ack0 !== 1'b0 || rdata !== 16'h0) begin
         errors++; $display("FAIL after_resp: busy=%b ack0=%b rdata=%h required 0", busy, ack0, rdata);
      end
   endtask

   task automatic test_alternate();
      int          k0, k1, n;
      bit          order [8];
      int unsigned base0, base1;
      reset_dut();
      base0 = n_ack0; base1 = n_ack1;
      k0 = 0; k1 = 0; n = 0;
      req0 = 1'b1; rw0 = RW_WRITE; addr0 = 16'd8;  wdata0 = 16'hA000;
      req1 = 1'b1; rw1 = RW_WRITE; addr1 = 16'd12; wdata1 = 16'hB000;
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
         @(negedge clock);
         if (ack0 && n < 8) begin
            order[n] = 1'b0; n++; k0++;
            if (k0 < 4) begin addr0 = 16'(8 + k0); wdata0 = 16'hA000 + 16'(k0); end
            else req0 = 1'b0;
         end
         if (ack1 && n < 8) begin
            order[n] = 1'b1; n++; k1++;
            if (k1 < 4) begin addr1 = 16'(12 + k1); wdata1 = 16'hB000 + 16'(k1); end
            else req1 = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (6) @(negedge clock);
      checks++;
      if (n !== 8) begin
         errors++; $display("FAIL alt_count: got %0d acks required 8", n);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (order[i] !== 1'(i % 2)) begin
            errors++; $display("FAIL alt_order[%0d]: got requester %0d required %0d", i, order[i], i % 2);
         end
      end
      checks++;
      if (n_ack0 - base0 !== 4 || n_ack1 - base1 !== 4) begin
         errors++; $display("FAIL alt_ack_total: ack0=%0d ack1=%0d required 4/4", n_ack0 - base0, n_ack1 - base1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[8 + i] !== 16'hA000 + 16'(i) || mem[12 + i] !== 16'hB000 + 16'(i)) begin
            errors++; $display("FAIL alt_mem[%0d]: got %h/%h required %h/%h", i, mem[8 + i], mem[12 + i], 16'hA000 + 16'(i), 16'hB000 + 16'(i));
         end
      end
   endtask

   task automatic test_out_of_range();
      @(negedge clock);
      req1 = 1'b1; rw1 = RW_READ; addr1 = 16'h0010;
      @(negedge clock);
      checks++;
      if (mem_memwrite !== 1'b0 || mem_memread !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL oor_access: wr=%b rd=%b busy=%b required 0/0/1", mem_memwrite, mem_memread, busy);
      end
      checks++;
      if (mem_address !== 16'h0010) begin
         errors++; $display("FAIL oor_addr: got %h required 0010", mem_address);
      end
      @(negedge clock);
      checks++;
      if (ack1 !== 1'b1 || ack0 !== 1'b0 || err !== 1'b1 || rdata !== 16'h0) begin
         errors++; $display("FAIL oor_resp: ack1=%b ack0=%b err=%b rdata=%h required 1/0/1/0000", ack1, ack0, err, rdata);
      end
      addr1 = 16'd15;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (mem_memread !== 1'b1) begin
         errors++; $display("FAIL edge15_access: rd=%b required 1", mem_memread);
      end
      @(negedge clock);
      checks++;
      if (ack1 !== 1'b1 || err !== 1'b0 || rdata !== 16'hB003) begin
         errors++; $display("FAIL edge15_resp: ack1=%b err=%b rdata=%h required 1/0/b003", ack1, err, rdata);
      end
      req1 = 1'b0;
      @(negedge clock);
      checks++;
      if (err !== 1'b0 || ack1 !== 1'b0) begin
         errors++; $display("FAIL oor_after: err=%b ack1=%b required 0", err, ack1);
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clock);
      req0 = 1'b1; rw0 = RW_WRITE; addr0 = 16'd5; wdata0 = 16'h1234;
      @(negedge clock);
      checks++;
      if (mem_memwrite !== 1'b1) begin
         errors++; $display("FAIL abort_pre: wr=%b required 1", mem_memwrite);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (mem_memwrite !== 1'b0 || mem_memread !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0) begin
         errors++; $display("FAIL abort_async: wr=%b rd=%b busy=%b ack0=%b required 0", mem_memwrite, mem_memread, busy, ack0);
      end
      req0 = 1'b0;
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b0 || mem[5] !== 16'h1005) begin
         errors++; $display("FAIL abort_nowrite: ack0=%b mem5=%h required 0/1005", ack0, mem[5]);
      end
      reset = 1'b0;
      req0 = 1'b1; rw0 = RW_READ; addr0 = 16'd5;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1 || rdata !== 16'h1005) begin
         errors++; $display("FAIL abort_readback: ack0=%b rdata=%h required 1/1005", ack0, rdata);
      end
      req0 = 1'b0;
      @(negedge clock);
      req0 = 1'b1; rw0 = RW_READ; addr0 = 16'd3;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1) begin
         errors++; $display("FAIL resp_pre: ack0=%b required 1", ack0);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (ack0 !== 1'b0 || rdata !== 16'h0 || busy !== 1'b0) begin
         errors++; $display("FAIL resp_cancel: ack0=%b rdata=%h busy=%b required 0", ack0, rdata, busy);
      end
      req0 = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_single_req1();
      int          k;
      int unsigned stamp [3];
      // A req0 grant leaves the priority bit pointing at requester 1.
      @(negedge clock);
      req0 = 1'b1; rw0 = RW_READ; addr0 = 16'd3;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1 || rdata !== 16'hBEEF) begin
         errors++; $display("FAIL reissue: ack0=%b rdata=%h required 1/beef", ack0, rdata);
      end
      req0 = 1'b0;
      @(negedge clock);
      k = 0;
      req1 = 1'b1; rw1 = RW_READ; addr1 = 16'd0;
      for (int cyc = 1; cyc <= 30 && k < 3; cyc++) begin
         @(negedge clock);
         if (ack1) begin
            stamp[k] = cyc;
            checks++;
            if (rdata !== 16'h1000 + 16'(k)) begin
               errors++; $display("FAIL single_rdata[%0d]: got %h required %h", k, rdata, 16'h1000 + 16'(k));
            end
            k++;
            if (k < 3) addr1 = 16'(k);
            else req1 = 1'b0;
         end
      end
      checks++;
      if (k !== 3) begin
         errors++; $display("FAIL single_count: got %0d acks required 3", k);
      end else begin
         checks++;
         if (stamp[0] !== 2 || stamp[1] - stamp[0] !== 3 || stamp[2] - stamp[1] !== 3) begin
            errors++; $display("FAIL single_spacing: got %0d,%0d,%0d required 2,5,8", stamp[0], stamp[1], stamp[2]);
         end
      end
      repeat (2) @(negedge clock);
      req0 = 1'b1; rw0 = RW_READ; addr0 = 16'd0;
      req1 = 1'b1; rw1 = RW_READ; addr1 = 16'd1;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 16'h1000) begin
         errors++; $display("FAIL prio_end: ack0=%b ack1=%b rdata=%h required 1/0/1000", ack0, ack1, rdata);
      end
      req0 = 1'b0;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (ack1 !== 1'b1 || rdata !== 16'h1001) begin
         errors++; $display("FAIL loser_served: ack1=%b rdata=%h required 1/1001", ack1, rdata);
      end
      req1 = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; mem_load = 1'b1;
      req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
      test_reset();
      mon_en = 1'b1;
      test_write_read();
      test_alternate();
      test_out_of_range();
      test_reset_mid_access();
      test_single_req1();
      repeat (3) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
